// File: rtl/mips_bus_mem_ws.sv
// Avalon-style word memory slave with programmable or LFSR-driven waitrequest stalls,
// byte-lane writes, address decode with error pulses, and a stall-cycle counter.
module mips_bus_mem_ws #(
    parameter string       RAM_INIT_FILE = "",
    parameter logic [31:0] ADDR_BASE     = 32'hBFC00000,
    parameter int          DEPTH_WORDS   = 4096,
    parameter int          READ_WAIT     = 1,
    parameter int          WRITE_WAIT    = 1,
    parameter int          WAIT_MODE     = 0,
    parameter int          MAX_WAIT      = 7,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    output logic [31:0] stall_count
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    logic [31:0]   mem [DEPTH_WORDS];
    state_t        state;
    logic [3:0]    cnt;
    logic [15:0]   lfsr;
    logic [31:0]   rd_q;

    logic          req;
    logic          bad;
    logic          completing;
    logic [29:0]   word_off;
    logic [AW-1:0] idx;
    logic [3:0]    rand_wait;
    logic [3:0]    n_wait;
    logic [31:0]   rd_val;

    assign req       = read | write;
    assign word_off  = address[31:2] - ADDR_BASE[31:2];
    assign idx       = word_off[AW-1:0];
    assign bad       = (address < ADDR_BASE) || (word_off[29:AW] != '0) ||
                       (address[1:0] != 2'b00) || (read && write);
    assign rand_wait = (lfsr[3:0] > 4'(MAX_WAIT)) ? 4'(MAX_WAIT) : lfsr[3:0];
    assign n_wait    = (WAIT_MODE != 0) ? rand_wait :
                       (read ? 4'(READ_WAIT) : 4'(WRITE_WAIT));

    // Reset forces the bus quiet: nothing completes and nothing stalls while reset_n is low.
    assign completing  = reset_n & req &
                         (((state == S_IDLE) && (n_wait == 4'd0)) || (state == S_ACK));
    assign waitrequest = reset_n & req & ~completing;
    assign rd_val      = bad ? 32'h0 : mem[idx];
    assign readdata    = (completing && read) ? rd_val : rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            lfsr        <= LFSR_SEED;
            err         <= 1'b0;
            stall_count <= 32'd0;
            rd_q        <= 32'd0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
            err  <= completing & bad;
            if (req && waitrequest)
                stall_count <= stall_count + 32'd1;
            if (completing && read)
                rd_q <= rd_val;
            case (state)
                S_IDLE: begin
                    // The IDLE cycle is the first stall, so WAIT covers the remaining N-1.
                    if (req && (n_wait == 4'd1)) begin
                        state <= S_ACK;
                    end else if (req && (n_wait != 4'd0)) begin
                        cnt   <= n_wait - 4'd2;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req)
                        state <= S_IDLE;
                    else if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= S_ACK;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (completing && write && !bad) begin
            for (int i = 0; i < 4; i++)
                if (byteenable[i])
                    mem[idx][8*i +: 8] <= writedata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_mips_bus_mem_ws.sv
// Scoreboard bench for mips_bus_mem_ws: three instances (fixed waits, zero-wait reads, random waits)
// driven with directed and random traffic against a word-array memory model.
module tb_mips_bus_mem_ws;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 64;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        logic        err;
        int          stall;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        rd_s    [3];
    logic        wr_s    [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [3:0]  be_s    [3];
    logic        waitreq_s [3];
    logic [31:0] rdata_s   [3];
    logic        err_s     [3];
    logic [31:0] scnt_s    [3];

    logic [31:0] mdl [3][DEPTH];
    exp_t        sbq [3][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // monitor state
    int          stall_run [3];
    logic [31:0] stall_sum [3];
    logic        cmpl_prev [3];
    logic        err_exp   [3];
    logic [31:0] last_rd   [3];
    logic        m_cmpl;
    logic        m_req;
    logic        m_err_want;
    exp_t        m_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_bus_mem_ws #(
            .RAM_INIT_FILE (""),
            .ADDR_BASE     (BASE),
            .DEPTH_WORDS   (DEPTH),
            .READ_WAIT     (g == 0 ? 2 : 0),
            .WRITE_WAIT    (g == 0 ? 0 : (g == 1 ? 3 : 0)),
            .WAIT_MODE     (g == 2 ? 1 : 0),
            .MAX_WAIT      (3),
            .LFSR_SEED     (16'hACE1)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .address     (addr_s[g]),
            .read        (rd_s[g]),
            .write       (wr_s[g]),
            .writedata   (wdata_s[g]),
            .byteenable  (be_s[g]),
            .waitrequest (waitreq_s[g]),
            .readdata    (rdata_s[g]),
            .err         (err_s[g]),
            .stall_count (scnt_s[g])
        );
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    function automatic int exp_stall(int d, logic rd);
        if (d == 2) return -1;
        if (d == 0) return rd ? 2 : 0;
        return rd ? 0 : 3;
    endfunction

    // Issue one transfer; caller is just after a rising edge. Returns just after the completing edge.
    task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        logic ok;
        int   wi;
        bit   done;
        wi = 0;
        ok = (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4)) && (a[1:0] == 2'b00) && !(rd && wr);
        if (ok) wi = int'((a - BASE) >> 2);
        e.is_rd = rd;
        e.err   = !ok;
        e.data  = (rd && ok) ? mdl[d][wi] : 32'h0;
        e.stall = exp_stall(d, rd);
        if (wr && ok)
            for (int i = 0; i < 4; i++)
                if (be[i]) mdl[d][wi][8*i +: 8] = wd[8*i +: 8];
        sbq[d].push_back(e);
        rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = a; wdata_s[d] = wd; be_s[d] = be;
        done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!waitreq_s[d]) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: waitrequest still 1 after 40 cycles, required 0", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every completion and checks data, stalls, err and hold behaviour.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!reset_n) begin
                stall_run[d] = 0;
                stall_sum[d] = 32'd0;
                cmpl_prev[d] = 1'b0;
                err_exp[d]   = 1'b0;
                last_rd[d]   = 32'd0;
                sbq[d].delete();
            end else begin
                m_req      = rd_s[d] | wr_s[d];
                m_cmpl     = m_req & ~waitreq_s[d];
                m_err_want = cmpl_prev[d] ? err_exp[d] : 1'b0;
                chk("err", d, {31'd0, err_s[d]}, {31'd0, m_err_want});
                if (m_cmpl) begin
                    if (sbq[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion dut%0d: got completion, required none", d);
                        cmpl_prev[d] = 1'b0;
                    end else begin
                        m_e = sbq[d].pop_front();
                        if (m_e.stall < 0)
                            chk("rnd_stall_le3", d, {31'd0, stall_run[d] <= 3}, 32'd1);
                        else
                            chk("stall_cycles", d, 32'(stall_run[d]), 32'(m_e.stall));
                        if (m_e.is_rd) begin
                            chk("readdata", d, rdata_s[d], m_e.data);
                            last_rd[d] = m_e.data;
                        end
                        stall_sum[d] = stall_sum[d] + 32'(stall_run[d]);
                        chk("stall_count", d, scnt_s[d], stall_sum[d]);
                        cmpl_prev[d] = 1'b1;
                        err_exp[d]   = m_e.err;
                    end
                    stall_run[d] = 0;
                end else begin
                    cmpl_prev[d] = 1'b0;
                    if (m_req && waitreq_s[d]) stall_run[d]++;
                end
                if (!(m_cmpl && rd_s[d]))
                    chk("readdata_hold", d, rdata_s[d], last_rd[d]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        logic [31:0] s0;
        int k, op, n;
        logic [31:0] a;
        logic rd, wr;

        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rd_s[d] = 0; wr_s[d] = 0; addr_s[d] = 0; wdata_s[d] = 0; be_s[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_waitrequest", d, {31'd0, waitreq_s[d]}, 32'd0);
            chk("rst_readdata", d, rdata_s[d], 32'd0);
            chk("rst_err", d, {31'd0, err_s[d]}, 32'd0);
            chk("rst_stall_count", d, scnt_s[d], 32'd0);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // preload every word of every instance
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < DEPTH; i++)
                access(d, 0, 1, BASE + 32'(4 * i), $urandom, 4'hF);
            idle(d);
        end

        // fixed READ_WAIT=2 read of the reset-vector word
        access(0, 0, 1, BASE, 32'h24020005, 4'hF);
        access(0, 1, 0, BASE, 32'h0, 4'h0);
        idle(0);

        // byte-lane write on a zeroed word, then a byteenable=0 no-op
        access(0, 0, 1, BASE + 32'h10, 32'h0, 4'hF);
        access(0, 0, 1, BASE + 32'h10, 32'hAABBCCDD, 4'b0101);
        access(0, 1, 0, BASE + 32'h10, 32'h0, 4'h0);
        idle(0);
        chk("lane_write_word", 0, mdl[0][4], 32'h00BB00DD);
        access(0, 0, 1, BASE + 32'h10, 32'hFFFFFFFF, 4'h0);
        access(0, 1, 0, BASE + 32'h10, 32'h0, 4'h0);
        idle(0);

        // back-to-back zero-wait reads
        s0 = scnt_s[1];
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            access(1, 1, 0, BASE + 32'(4 * i), 32'h0, 4'h0);
        c1 = cyc;
        idle(1);
        chk("b2b_cycles", 1, 32'(c1 - c0), 32'd8);
        chk("b2b_no_stall", 1, scnt_s[1], s0);

        // erroneous accesses on every instance
        for (int d = 0; d < 3; d++) begin
            access(d, 1, 0, 32'h00000000, 32'h0, 4'h0);
            access(d, 1, 0, BASE + 32'h2, 32'h0, 4'h0);
            access(d, 1, 0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0);
            access(d, 0, 1, BASE - 32'h4, 32'h12345678, 4'hF);
            access(d, 1, 1, BASE + 32'h8, 32'hCAFEF00D, 4'hF);
            access(d, 1, 0, BASE + 32'h8, 32'h0, 4'h0);
            idle(d);
        end

        // random traffic
        for (int d = 0; d < 3; d++) begin
            n = (d == 2) ? 1000 : 200;
            for (int t = 0; t < n; t++) begin
                k = $urandom_range(0, 19);
                if (k == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
                else if (k == 1) a = BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 7));
                else if (k == 2) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                op = $urandom_range(0, 19);
                rd = (op < 15) || (op == 19);
                wr = (op >= 15);
                access(d, rd, wr, a, $urandom, 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) idle(d);
            end
            idle(d);
        end

        // reset asserted while a write is stalled
        access(1, 0, 1, BASE + 32'h14, 32'h11223344, 4'hF);
        idle(1);
        rd_s[1] = 0; wr_s[1] = 1; addr_s[1] = BASE + 32'h14; wdata_s[1] = 32'hDEADBEEF; be_s[1] = 4'hF;
        @(negedge clk);
        chk("midwrite_stalled", 1, {31'd0, waitreq_s[1]}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midwrite_wait_drop", 1, {31'd0, waitreq_s[1]}, 32'd0);
        chk("midwrite_stall_count", 1, scnt_s[1], 32'd0);
        @(posedge clk);
        #1 wr_s[1] = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        access(1, 1, 0, BASE + 32'h14, 32'h0, 4'h0);
        idle(1);
        chk("midwrite_word_kept", 1, mdl[1][5], 32'h11223344);

        // contents survive reset on all instances
        for (int d = 0; d < 3; d++) begin
            for (int j = 0; j < 4; j++)
                access(d, 1, 0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0, 4'h0);
            idle(d);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            chk("scoreboard_empty", d, 32'(sbq[d].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
